button_debounce_multi: RTL
==========================

# button_debounce_multi

Parametrised N-channel push-button conditioner between the board pins and the user-interface control logic. Each channel synchronises its raw input, rejects bounce with a per-channel stability counter, and reports a debounced level. It also reports one-cycle press, release, long-press and auto-repeat events. It supersedes the single-channel debouncer for multi-button front panels.

## Interface
- N_CH, 4: number of independent button channels.
- STABLE_CYCLES, 65535: consecutive cycles a synchronised input must differ from the debounced level before the level flips (≥2).
- LONG_CYCLES, 25000000: cycles of continuous debounced press before `btn_long` fires (≥1).
- REPEAT_CYCLES, 5000000: auto-repeat period after the long press; 0 disables repeat.
- ACTIVE_LOW, {N_CH{1'b0}}: per-channel mask; bit set means the pin reads 0 when pressed.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- btn_in  in  N_CH  raw asynchronous button pins.
- btn_state  out  N_CH  debounced level, 1 = pressed (polarity normalised).
- btn_rise  out  N_CH  one-cycle pulse on debounced press.
- btn_fall  out  N_CH  one-cycle pulse on debounced release.
- btn_long  out  N_CH  one-cycle pulse when the press has lasted LONG_CYCLES.
- btn_repeat  out  N_CH  one-cycle pulse every REPEAT_CYCLES after `btn_long` while still held.

## Operation
- Per channel: `p = btn_in[i] ^ ACTIVE_LOW[i]`, then two-flop synchroniser s1→s2. All channels are fully independent; no shared state.
- Stability counter `cnt`, width $clog2(STABLE_CYCLES). If s2 == btn_state, cnt <= 0. Otherwise, if cnt == STABLE_CYCLES-1, btn_state <= s2 and cnt <= 0. Otherwise cnt <= cnt+1. Any return of s2 to the current level restarts the count.
- `btn_rise` and `btn_fall` are registered, asserted for exactly the cycle in which btn_state first shows the new value.
- Hold FSM per channel, states IDLE, HOLD, REPEAT:
  - IDLE→HOLD on debounced press, hold counter cleared.
  - HOLD: counter increments each cycle. On reaching LONG_CYCLES, pulse btn_long. Go to REPEAT if REPEAT_CYCLES>0, otherwise stay in HOLD with the counter saturated and no further pulses.
  - REPEAT: counter reloads and pulses btn_repeat every REPEAT_CYCLES cycles.
  - Debounced release from any state → IDLE, counters cleared. No btn_long or btn_repeat is issued in or after the release cycle.
- Hold counter width is $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1) and never wraps.
- Reset: s1/s2 load the released level (0 after normalisation), so an ACTIVE_LOW pin idling high produces no event after reset. All counters are 0, FSM is IDLE, and btn_state, btn_rise, btn_fall, btn_long and btn_repeat are all 0. Reset mid-count discards progress; the first cycle after reset deasserts behaves as a fresh start.

## Timing
- The raw input change is first captured into s1 at edge E0. btn_state and btn_rise/btn_fall update at edge E0+STABLE_CYCLES+1.
- A raw pulse lasting ≤ STABLE_CYCLES-1 cycles produces no event. A pulse lasting exactly STABLE_CYCLES cycles produces a rise, then a fall.
- btn_long is high in the cycle starting LONG_CYCLES edges after the btn_rise cycle begins. btn_repeat pulses at +REPEAT_CYCLES, +2·REPEAT_CYCLES, … after btn_long.
- btn_rise and btn_fall are never both high on one channel in the same cycle. btn_long and btn_repeat are mutually exclusive.
- No input handshake; outputs are registered, with zero combinational path from btn_in.

## Test plan
Parameters for all scenarios: N_CH=2, STABLE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=2'b10.

- **Bounce rejection:** ch0 raw toggles 1,0,1,0 with 1–3-cycle widths, then holds 0 → btn_state[0] stays 0; no rise or fall pulses.
- **Clean press:** ch0 goes 1 before edge 0 and stays → btn_state[0] and a one-cycle btn_rise[0] appear after edge 5. btn_long[0] fires in the cycle after edge 15. btn_repeat[0] fires after edges 18, 21 and 24.
- **Release before long:** ch0 press held 8 debounced cycles, then released → btn_fall[0] once, 5 edges after the raw release. No btn_long[0].
- **Threshold pulse:** ch0 raw high for exactly 4 cycles → one btn_rise[0] followed by one btn_fall[0]. A 3-cycle pulse → nothing.
- **Active-low and independence:** btn_in[1] idles 1 through reset → no event. Driving btn_in[1]=0 while ch0 bounces → ch1 rise after 5 edges, unaffected by ch0.
- **Reset mid-operation:** assert rst for 1 cycle during ch0 hold at hold count 7 → all outputs 0 next cycle. The held press is re-debounced, and btn_rise[0] fires 5 edges after rst deasserts.

Source files
------------

// File: rtl/button_debounce_multi.sv
// N-channel push-button conditioner: two-flop synchroniser, stability-count debounce,
// and registered press/release/long-press/auto-repeat pulses per channel.
module button_debounce_multi #(
   parameter int unsigned     N_CH          = 4,
   parameter int unsigned     STABLE_CYCLES = 65535,
   parameter int unsigned     LONG_CYCLES   = 25000000,
   parameter int unsigned     REPEAT_CYCLES = 5000000,
   parameter logic [N_CH-1:0] ACTIVE_LOW    = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_state,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic [N_CH-1:0] btn_long,
   output logic [N_CH-1:0] btn_repeat
);

   localparam int unsigned CW       = $clog2(STABLE_CYCLES);
   localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] LONG_SAT  = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] RPT_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} hold_state_t;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic          s1, s2, level, flip;
      logic          rise_q, fall_q, long_q, rpt_q, long_d, rpt_d;
      logic [CW-1:0] cnt;
      logic [HW-1:0] hcnt, hcnt_d;
      hold_state_t   hs, hs_d;

      // Level flips on the edge where the last of STABLE_CYCLES differing samples is seen
      assign flip = (s2 != level) && (cnt == CNT_LAST);

      always_ff @(posedge clk) begin
         if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            s1     <= btn_in[i] ^ ACTIVE_LOW[i];
            s2     <= s1;
            rise_q <= flip & s2;
            fall_q <= flip & ~s2;
            if (s2 == level) begin
               cnt <= '0;
            end else if (flip) begin
               level <= s2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            hs     <= IDLE;
            hcnt   <= '0;
            long_q <= 1'b0;
            rpt_q  <= 1'b0;
         end else begin
            hs     <= hs_d;
            hcnt   <= hcnt_d;
            long_q <= long_d;
            rpt_q  <= rpt_d;
         end
      end

      // Release takes priority so no long/repeat pulse can coincide with the fall
      always_comb begin
         hs_d   = hs;
         hcnt_d = hcnt;
         long_d = 1'b0;
         rpt_d  = 1'b0;
         if (flip && !s2) begin
            hs_d   = IDLE;
            hcnt_d = '0;
         end else begin
            unique case (hs)
               IDLE: begin
                  if (flip) begin
                     hs_d   = HOLD;
                     hcnt_d = '0;
                  end
               end
               HOLD: begin
                  if (hcnt == LONG_LAST) begin
                     long_d = 1'b1;
                     if (REPEAT_CYCLES != 0) begin
                        hs_d   = REPEAT;
                        hcnt_d = '0;
                     end else begin
                        hcnt_d = LONG_SAT;
                     end
                  end else if (hcnt != LONG_SAT) begin
                     hcnt_d = hcnt + HW'(1);
                  end
               end
               REPEAT: begin
                  if (hcnt == RPT_LAST) begin
                     rpt_d  = 1'b1;
                     hcnt_d = '0;
                  end else begin
                     hcnt_d = hcnt + HW'(1);
                  end
               end
               default: begin
                  hs_d   = IDLE;
                  hcnt_d = '0;
               end
            endcase
         end
      end

      assign btn_state[i]  = level;
      assign btn_rise[i]   = rise_q;
      assign btn_fall[i]   = fall_q;
      assign btn_long[i]   = long_q;
      assign btn_repeat[i] = rpt_q;
   end

endmodule
